// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, blanking and start-of-line/frame strobes, all aligned to hpos/vpos.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] hpos_next;
  logic [9:0] vpos_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       visible_next;
  logic       line_start_next;
  logic       frame_start_next;
  logic [9:0] frame_count_next;
  logic       h_wrap;

  // Every strobe is decoded from the next counter values so that, once
  // registered, it lines up with the hpos/vpos presented in the same cycle.
  always_comb begin
    h_wrap    = (hpos == H_MAX);
    hpos_next = h_wrap ? 10'd0 : hpos + 10'd1;
    vpos_next = vpos;
    if (h_wrap) begin
      vpos_next = (vpos == V_MAX) ? 10'd0 : vpos + 10'd1;
    end

    hsync_next = ~SYNC_POL;
    if (hpos_next >= HS_FIRST && hpos_next <= HS_LAST) begin
      hsync_next = SYNC_POL;
    end
    vsync_next = ~SYNC_POL;
    if (vpos_next >= VS_FIRST && vpos_next <= VS_LAST) begin
      vsync_next = SYNC_POL;
    end

    visible_next     = (hpos_next < H_VIS) && (vpos_next < V_VIS);
    line_start_next  = (hpos_next == 10'd0);
    frame_start_next = (hpos_next == 10'd0) && (vpos_next == 10'd0);
    frame_count_next = frame_start_next ? frame_count + 10'd1 : frame_count;
  end

  // Reset parks the counters on the last pixel of the last line so the first
  // live edge wraps both to zero and starts frame 0 (count 1023 -> 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= H_MAX;
      vpos        <= V_MAX;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 10'd1023;
    end else begin
      hpos        <= hpos_next;
      vpos        <= vpos_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      visible     <= visible_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
      frame_count <= frame_count_next;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, active level of hsync/vsync (0 = active-low).
REQ-010 SHALL have port clk  input  1  pixel clock; one clock, all state on its rising edge.
REQ-011 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-012 SHALL have port hsync  output  1  horizontal sync, registered.
REQ-013 SHALL have port vsync  output  1  vertical sync, registered.
REQ-014 SHALL have port hpos  output  10  current pixel column, registered.
REQ-015 SHALL have port vpos  output  10  current line, registered.
REQ-016 SHALL have port visible  output  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-017 SHALL have port line_start  output  1  one-cycle pulse when hpos = 0.
REQ-018 SHALL have port frame_start  output  1  one-cycle pulse when hpos = 0 and vpos = 0.
REQ-019 SHALL have port frame_count  output  10  frames started since reset, modulo 1024.

Function
REQ-020 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-021 hpos SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-022 vpos SHALL increment by 1 only on the clock where hpos wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same clock.
REQ-023 hsync SHALL equal SYNC_POL when hpos is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (default 656..751), else ~SYNC_POL.
REQ-024 vsync SHALL equal SYNC_POL when vpos is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (default 490..491), for the full line including blanking, else ~SYNC_POL.
REQ-025 hsync, vsync, visible, line_start and frame_start SHALL be registered and cycle-aligned with the hpos/vpos values presented in the same cycle (zero relative latency); they SHALL be computed from next-state counters, not decoded combinationally from outputs.
REQ-026 frame_count SHALL increment by 1 on the clock that frame_start goes high and wrap from 1023 to 0; it SHALL be stable for the rest of the frame.
REQ-027 No output SHALL glitch combinationally; every output SHALL be a flop.
REQ-028 Counter arithmetic SHALL be 10 bits; parameters giving H_TOTAL or V_TOTAL > 1024 are unsupported.

Reset
REQ-029 While rst_n = 0: hpos = H_TOTAL-1, vpos = V_TOTAL-1, hsync = ~SYNC_POL, vsync = ~SYNC_POL, visible = 0, line_start = 0, frame_start = 0, frame_count = 1023, regardless of clk.
REQ-030 The first rising clk edge with rst_n = 1 SHALL produce hpos = 0, vpos = 0, visible = 1, line_start = 1, frame_start = 1, frame_count = 0.
REQ-031 Reset asserted mid-frame SHALL immediately force REQ-029 values; no partial line or frame state SHALL survive.

Verification
REQ-032 Release reset, run 1 clock -> hpos=0, vpos=0, visible=1, frame_start=1, line_start=1, frame_count=0.
REQ-033 Run 800 clocks from frame start -> hpos wraps 799->0, vpos 0->1, line_start pulses once, frame_start stays 0.
REQ-034 Observe line 0 -> hsync low exactly for hpos 656..751 (96 clocks); visible low for hpos 640..799.
REQ-035 Run a full frame (420000 clocks) -> vsync low exactly for vpos 490..491 (1600 clocks); frame_start pulses once per 420000 clocks; frame_count 0->1.
REQ-036 Run 1024 frames -> frame_count wraps 1023->0 on the frame_start pulse.
REQ-037 Assert rst_n low at hpos=300, vpos=200, asynchronous to clk -> outputs take REQ-029 values before the next clk edge; release -> REQ-030 sequence repeats.
